// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: FSM state encodings,
// operand width and start-to-done latency so the control unit can size its wait states.
package mult_div_unit_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int MD_CNT_W   = 6;
    localparam int MD_LATENCY = 33;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mult_div_unit_md_step.sv
// One combinational iteration of the unit: a radix-2 Booth add/sub with arithmetic
// shift, and a restoring-division trial subtract with left shift.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   booth_acc_o,
    output logic [WIDTH-1:0] booth_q_o,
    output logic             booth_qm1_o,
    output logic [WIDTH-1:0] div_rem_o,
    output logic [WIDTH-1:0] div_quo_o
);

    // Accumulator carries one guard bit so a -2**(WIDTH-1) multiplicand cannot overflow.
    logic [WIDTH:0] sum;

    always_comb begin
        case ({q_i[0], qm1_i})
            2'b01:   sum = acc_i + m_i;
            2'b10:   sum = acc_i - m_i;
            default: sum = acc_i;
        endcase
    end

    assign booth_acc_o = {sum[WIDTH], sum[WIDTH:1]};
    assign booth_q_o   = {sum[0], q_i[WIDTH-1:1]};
    assign booth_qm1_o = q_i[0];

    // Remainder lives in acc_i[WIDTH-1:0]; the dividend shifts out of q_i as quotient bits shift in.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    assign shifted   = {acc_i[WIDTH-1:0], q_i[WIDTH-1]};
    assign diff      = {1'b0, shifted} - {2'b00, m_i[WIDTH-1:0]};
    assign div_rem_o = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign div_quo_o = {q_i[WIDTH-2:0], ~diff[WIDTH+1]};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit (WIDTH steps per operation).
// Optional MULTDIV_UNSIGNED_EN adds isUnsigned for multu/divu.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             initMult,
    input  logic             initDiv,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             isUnsigned,
`endif
    input  logic [WIDTH-1:0] Avalue,
    input  logic [WIDTH-1:0] Bvalue,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [1:0]       dbg_state
);

    // Handshake: a start pulse is accepted only on an edge where busy=0; done is a
    // one-cycle pulse with hi/lo/divByZero valid, and the unit is idle on the next edge.
    logic             uns;
`ifdef MULTDIV_UNSIGNED_EN
    assign uns = isUnsigned;
`else
    assign uns = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH:0]   m_q, m_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             fix_q, fix_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_q;
    logic             booth_qm1;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic             last_step;
    logic             a_neg, b_neg;

    md_step #(.WIDTH(WIDTH)) u_step (
        .acc_i       (acc_q),
        .q_i         (q_q),
        .qm1_i       (qm1_q),
        .m_i         (m_q),
        .booth_acc_o (booth_acc),
        .booth_q_o   (booth_q),
        .booth_qm1_o (booth_qm1),
        .div_rem_o   (div_rem),
        .div_quo_o   (div_quo)
    );

    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
    assign a_neg     = ~uns & Avalue[WIDTH-1];
    assign b_neg     = ~uns & Bvalue[WIDTH-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        fix_d     = fix_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (initMult) begin
                    state_d = ST_MULT;
                    cnt_d   = '0;
                    acc_d   = '0;
                    q_d     = Bvalue;
                    qm1_d   = 1'b0;
                    m_d     = {a_neg, Avalue};
                    // Booth reads an unsigned multiplier with MSB set as negative; add A back into hi.
                    fix_d   = uns & Bvalue[WIDTH-1];
                    dbz_d   = 1'b0;
                end else if (initDiv) begin
                    if (Bvalue == '0) begin
                        state_d = ST_DONE;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d   = ST_DIV;
                        cnt_d     = '0;
                        acc_d     = '0;
                        q_d       = a_neg ? -Avalue : Avalue;
                        m_d       = {1'b0, (b_neg ? -Bvalue : Bvalue)};
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        dbz_d     = 1'b0;
                    end
                end
            end
            ST_MULT: begin
                acc_d = booth_acc;
                q_d   = booth_q;
                qm1_d = booth_qm1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    state_d = ST_DONE;
                    hi_d    = booth_acc[WIDTH-1:0] + (fix_q ? m_q[WIDTH-1:0] : '0);
                    lo_d    = booth_q;
                end
            end
            ST_DIV: begin
                acc_d = {1'b0, div_rem};
                q_d   = div_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    state_d = ST_DONE;
                    lo_d    = neg_quo_q ? -div_quo : div_quo;
                    hi_d    = neg_rem_q ? -div_rem : div_rem;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            fix_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            fix_q     <= fix_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign divByZero = dbz_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases, reset abort, start collisions
// and random signed operations against a behavioural model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         initMult = 1'b0;
    logic         initDiv = 1'b0;
    logic [W-1:0] Avalue = '0;
    logic [W-1:0] Bvalue = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done, divByZero;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [2*W:0] exp_q[$];   // {divByZero, hi, lo}

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .initMult  (initMult),
        .initDiv   (initDiv),
        .Avalue    (Avalue),
        .Bvalue    (Bvalue),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W:0] mult_model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return {1'b0, 64'(p)};
    endfunction

    function automatic logic [2*W:0] div_model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint qv, rv;
        qv = longint'($signed(a)) / longint'($signed(b));
        rv = longint'($signed(a)) % longint'($signed(b));
        return {1'b0, 32'(rv), 32'(qv)};
    endfunction

    // Wait for done from the current negedge; n counts edges since the sampling edge.
    task automatic wait_and_score(input string tag, input int n0, input int lat);
        int n;
        logic [2*W:0] e;
        n = n0;
        while (!done && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (done) begin
            check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
            check({tag, "_hi"}, 64'(hi), 64'(e[2*W-1:W]));
            check({tag, "_lo"}, 64'(lo), 64'(e[W-1:0]));
            check({tag, "_dbz"}, 64'(divByZero), 64'(e[2*W]));
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    task automatic drive_op(input string tag, input bit is_div, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [2*W:0] exp, input int lat);
        @(negedge clk);
        Avalue   = a;
        Bvalue   = b;
        initMult = !is_div;
        initDiv  = is_div;
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        initMult = 1'b0;
        initDiv  = 1'b0;
        Avalue   = $urandom;
        Bvalue   = $urandom;
        wait_and_score(tag, 1, lat);
    endtask

    initial begin
        int d0;
        logic [W-1:0] a, b;

        #2 reset = 1'b0;
        #10;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(divByZero), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        reset = 1'b1;

        drive_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, MD_LATENCY);
        drive_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, {1'b0, 32'h4000_0000, 32'h0}, MD_LATENCY);
        drive_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, MD_LATENCY);
        drive_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0, 32'h8000_0000}, MD_LATENCY);
        drive_op("div_5_2", 1'b1, 32'd5, 32'd2, {1'b0, 32'd1, 32'd2}, MD_LATENCY);
        drive_op("div_by_zero", 1'b1, 32'd5, 32'd0, {1'b1, 32'd1, 32'd2}, 1);

        // Asynchronous reset during a multiply.
        @(negedge clk);
        Avalue = 32'd3;
        Bvalue = 32'd4;
        initMult = 1'b1;
        @(posedge clk);
        @(negedge clk);
        initMult = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_state_before", 64'(dbg_state), 64'(ST_MULT));
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_dbz", 64'(divByZero), 64'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        drive_op("mul_after_rst", 1'b0, 32'd3, 32'd4, {1'b0, 32'd0, 32'd12}, MD_LATENCY);

        // Simultaneous starts, then a divide-by-zero start while busy.
        d0 = done_cnt;
        @(negedge clk);
        Avalue = 32'd6;
        Bvalue = 32'd3;
        initMult = 1'b1;
        initDiv = 1'b1;
        exp_q.push_back({1'b0, 32'd0, 32'd18});
        @(posedge clk);
        @(negedge clk);
        initMult = 1'b0;
        initDiv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        Bvalue = 32'd0;
        initDiv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        initDiv = 1'b0;
        wait_and_score("collide", 5, MD_LATENCY);
        repeat (40) @(negedge clk);
        check("collide_one_done", 64'(done_cnt - d0), 64'd1);

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            drive_op("rand_mul", 1'b0, a, b, mult_model(a, b), MD_LATENCY);
        end
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom) : 32'($urandom_range(1, 20));
            if (i % 4 == 3) b = -b;
            if (b == 0) b = 32'd1;
            drive_op("rand_div", 1'b1, a, b, div_model(a, b), MD_LATENCY);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
